block_check_sequencer: RTL and testbench

Front-end controller that sequences a begin/end nesting checker over whole character strings. Upstream pushes characters, one per handshake, with a last-flag on each string's final character. The block buffers each string in a small FIFO and resets the checker before the string. It then streams the string into the checker back-to-back, appends a terminating space, and reports the checker's verdict with a one-cycle `done` pulse. It sits between the host character source and the checker's `reset`/`in`/`result` pins.

---
 rtl/block_check_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_block_check_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_check_sequencer.sv
// Front-end sequencer for a begin/end nesting checker: buffers whole strings,
// resets the checker, streams each string plus a trailing space, and reports the verdict.
//
// state  | meaning
// IDLE   | waiting for a complete buffered string, or a full FIFO with no last-flag
// CLEAR  | checker reset is high; first character is popped onto chk_in
// FEED   | popping one character per cycle onto chk_in until the last-flagged one
// FLUSH  | drives the terminating space, then holds one cycle while the checker absorbs it
// SETTLE | samples the checker result and pulses done
// DROP   | over-length string: discard characters until its last-flag arrives
module block_check_sequencer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        chk_rst,
    output logic [7:0]  chk_in,
    input  logic        chk_result,
    output logic        done,
    output logic        pass,
    output logic        ovf,
    output logic [15:0] char_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [7:0]    SPACE = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_SETTLE,
        S_DROP
    } state_t;

    state_t state, state_nxt;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, last_cnt;
    logic [15:0]   len, drop_cnt;
    logic          flush_hold;

    logic [8:0]    head;
    logic          head_last;
    logic          push, push_fifo, pop;
    logic          start, report, drop_enter, drop_end;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign head      = mem[rd_ptr];
    assign head_last = head[8];
    assign in_ready  = (state == S_DROP) || (count != FULL);
    assign push      = in_valid && in_ready;
    assign push_fifo = push && (state != S_DROP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        start      = 1'b0;
        report     = 1'b0;
        drop_enter = 1'b0;
        drop_end   = 1'b0;
        case (state)
            S_IDLE: begin
                if (last_cnt != '0) begin
                    state_nxt = S_CLEAR;
                    start     = 1'b1;
                end else if (count == FULL) begin
                    state_nxt  = S_DROP;
                    drop_enter = 1'b1;
                end
            end
            S_CLEAR: begin
                pop       = 1'b1;
                state_nxt = head_last ? S_FLUSH : S_FEED;
            end
            S_FEED: begin
                pop = 1'b1;
                if (head_last) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_hold) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                report    = 1'b1;
                state_nxt = S_IDLE;
            end
            S_DROP: begin
                if (push && in_last) begin
                    drop_end  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Storage itself needs no reset; pointers and counters define what is valid.
    always_ff @(posedge clk) begin
        if (push_fifo) begin
            mem[wr_ptr] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_cnt <= '0;
        end else if (drop_enter) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_cnt <= '0;
        end else begin
            if (push_fifo) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count + CW'(push_fifo) - CW'(pop);
            last_cnt <= last_cnt + CW'(push_fifo && in_last) - CW'(pop && head_last);
        end
    end

    // FLUSH lasts two cycles so the checker has consumed the space before SETTLE samples it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_rst    <= 1'b0;
            chk_in     <= SPACE;
            done       <= 1'b0;
            pass       <= 1'b0;
            ovf        <= 1'b0;
            char_count <= '0;
            len        <= '0;
            drop_cnt   <= '0;
            flush_hold <= 1'b0;
        end else begin
            done       <= 1'b0;
            chk_rst    <= start;
            flush_hold <= (state == S_FLUSH) && !flush_hold;

            if (pop) begin
                chk_in <= head[7:0];
            end else if (state == S_FLUSH) begin
                chk_in <= SPACE;
            end

            if (state == S_CLEAR) begin
                len <= 16'd1;
            end else if (state == S_FEED) begin
                len <= sat_inc(len);
            end

            if (drop_enter) begin
                drop_cnt <= 16'(DEPTH);
            end else if (state == S_DROP && push) begin
                drop_cnt <= sat_inc(drop_cnt);
            end

            if (report) begin
                done       <= 1'b1;
                pass       <= chk_result;
                ovf        <= 1'b0;
                char_count <= len;
            end else if (drop_end) begin
                done       <= 1'b1;
                pass       <= 1'b0;
                ovf        <= 1'b1;
                char_count <= sat_inc(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_block_check_sequencer.sv
// Directed bench for block_check_sequencer: a DEPTH=16 and a DEPTH=8 instance,
// each driving a behavioural begin/end nesting checker.
module tb_block_check_sequencer;

    typedef struct packed {
        logic [7:0]  depth;
        logic        lock;
        logic [39:0] word;
        logic [2:0]  wlen;
    } ck_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic        in_valid16, in_last16, in_ready16, chk_rst16, chk_result16;
    logic        done16, pass16, ovf16;
    logic [7:0]  in_data16, chk_in16;
    logic [15:0] cnt16;
    logic        in_valid8, in_last8, in_ready8, chk_rst8, chk_result8;
    logic        done8, pass8, ovf8;
    logic [7:0]  in_data8, chk_in8;
    logic [15:0] cnt8;
    ck_t         ck16, ck8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    block_check_sequencer #(.DEPTH(16)) u_dut16 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_data(in_data16), .in_last(in_last16), .chk_rst(chk_rst16), .chk_in(chk_in16),
        .chk_result(chk_result16), .done(done16), .pass(pass16), .ovf(ovf16),
        .char_count(cnt16)
    );

    block_check_sequencer #(.DEPTH(8)) u_dut8 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .in_last(in_last8), .chk_rst(chk_rst8), .chk_in(chk_in8),
        .chk_result(chk_result8), .done(done8), .pass(pass8), .ovf(ovf8),
        .char_count(cnt8)
    );

    // Checker: case-insensitive words delimited by space; an unmatched end locks the result low.
    function automatic ck_t ck_step(input ck_t s, input logic rst, input logic [7:0] c);
        ck_t r;
        logic [7:0] lc;
        r = s;
        if (rst) begin
            r = '0;
        end else if (c == 8'h20) begin
            if (s.wlen == 3'd5 && s.word == "begin") begin
                r.depth = s.depth + 8'd1;
            end else if (s.wlen == 3'd3 && s.word[23:0] == "end") begin
                if (s.depth == 8'd0) r.lock = 1'b1;
                else r.depth = s.depth - 8'd1;
            end
            r.word = '0;
            r.wlen = '0;
        end else begin
            lc = (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
            if (s.wlen < 3'd5) r.word = {s.word[31:0], lc};
            if (s.wlen < 3'd6) r.wlen = s.wlen + 3'd1;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ck16 <= '0;
            ck8  <= '0;
        end else begin
            ck16 <= ck_step(ck16, chk_rst16, chk_in16);
            ck8  <= ck_step(ck8, chk_rst8, chk_in8);
        end
    end

    assign chk_result16 = !ck16.lock && (ck16.depth == 8'd0);
    assign chk_result8  = !ck8.lock && (ck8.depth == 8'd0);

    task automatic push(input int sel, input string s, output int stalls);
        int i;
        int guard;
        logic rdy;
        i = 0;
        guard = 0;
        stalls = 0;
        while (i < s.len() && guard < 200) begin
            if (sel == 1) begin
                in_valid8 = 1'b1; in_data8 = s[i]; in_last8 = (i == s.len() - 1);
                rdy = in_ready8;
            end else begin
                in_valid16 = 1'b1; in_data16 = s[i]; in_last16 = (i == s.len() - 1);
                rdy = in_ready16;
            end
            @(negedge clk);
            if (rdy) i++;
            else stalls++;
            guard++;
        end
        in_valid8 = 1'b0; in_last8 = 1'b0;
        in_valid16 = 1'b0; in_last16 = 1'b0;
        tests_run++;
        if (i != s.len()) begin
            tests_failed++;
            $display("FAIL push_timeout sel=%0d: accepted %0d chars, required %0d", sel, i, s.len());
        end
    endtask

    task automatic watch(input int sel, input string s, input logic exp_pass, output int rst_cyc);
        int guard;
        int n;
        logic seen, seq_ok, extra_rst, early_done;
        logic [7:0] got, expc, bad_got, bad_exp;
        n = s.len();
        guard = 0;
        seen = (sel == 1) ? chk_rst8 : chk_rst16;
        while (!seen && guard < 300) begin
            @(negedge clk);
            guard++;
            seen = (sel == 1) ? chk_rst8 : chk_rst16;
        end
        rst_cyc = cyc;
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL clear_timeout sel=%0d \"%s\": chk_rst never rose", sel, s);
        end else begin
            seq_ok = 1'b1; extra_rst = 1'b0; early_done = 1'b0;
            bad_got = 8'h00; bad_exp = 8'h00;
            for (int k = 1; k <= n + 1; k++) begin
                @(negedge clk);
                if (k <= n) expc = s[k-1];
                else expc = 8'h20;
                got = (sel == 1) ? chk_in8 : chk_in16;
                if (got !== expc && seq_ok) begin
                    seq_ok = 1'b0; bad_got = got; bad_exp = expc;
                end
                if ((sel == 1) ? chk_rst8 : chk_rst16) extra_rst = 1'b1;
                if ((sel == 1) ? done8 : done16) early_done = 1'b1;
            end
            tests_run++;
            if (!seq_ok) begin
                tests_failed++;
                $display("FAIL chk_in_seq \"%s\": got %h required %h", s, bad_got, bad_exp);
            end
            tests_run++;
            if (extra_rst !== 1'b0) begin
                tests_failed++;
                $display("FAIL chk_rst_width \"%s\": chk_rst high beyond one cycle", s);
            end
            @(negedge clk);
            if ((sel == 1) ? done8 : done16) early_done = 1'b1;
            tests_run++;
            if (early_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL done_early \"%s\": done before N+3", s);
            end
            @(negedge clk);
            tests_run++;
            if (((sel == 1) ? done8 : done16) !== 1'b1) begin
                tests_failed++;
                $display("FAIL done_at_n3 \"%s\": done=0 required 1", s);
            end
            tests_run++;
            if (((sel == 1) ? pass8 : pass16) !== exp_pass) begin
                tests_failed++;
                $display("FAIL pass \"%s\": got %b required %b", s,
                         ((sel == 1) ? pass8 : pass16), exp_pass);
            end
            tests_run++;
            if (((sel == 1) ? ovf8 : ovf16) !== 1'b0) begin
                tests_failed++;
                $display("FAIL ovf \"%s\": got 1 required 0", s);
            end
            tests_run++;
            if (((sel == 1) ? cnt8 : cnt16) !== 16'(n)) begin
                tests_failed++;
                $display("FAIL char_count \"%s\": got %0d required %0d", s,
                         ((sel == 1) ? cnt8 : cnt16), n);
            end
            @(negedge clk);
            tests_run++;
            if (((sel == 1) ? done8 : done16) !== 1'b0) begin
                tests_failed++;
                $display("FAIL done_width \"%s\": done still high at N+4", s);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        tests_run++;
        if ({chk_rst16, chk_in16, done16, pass16, ovf16, cnt16} !== {1'b0, 8'h20, 3'b000, 16'h0}) begin
            tests_failed++;
            $display("FAIL %s_dut16: rst=%b in=%h done=%b pass=%b ovf=%b cnt=%0d required 0 20 0 0 0 0",
                     tag, chk_rst16, chk_in16, done16, pass16, ovf16, cnt16);
        end
        tests_run++;
        if ({chk_rst8, chk_in8, done8, pass8, ovf8, cnt8} !== {1'b0, 8'h20, 3'b000, 16'h0}) begin
            tests_failed++;
            $display("FAIL %s_dut8: rst=%b in=%h done=%b pass=%b ovf=%b cnt=%0d required 0 20 0 0 0 0",
                     tag, chk_rst8, chk_in8, done8, pass8, ovf8, cnt8);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({in_ready16, in_ready8} !== 2'b11) begin
            tests_failed++;
            $display("FAIL in_ready_after_reset: got %b%b required 11", in_ready16, in_ready8);
        end
        check_reset_values("reset_release");
    endtask

    task automatic test_string(input int sel, input string s, input logic exp_pass);
        int st, rc;
        fork
            push(sel, s, st);
            watch(sel, s, exp_pass, rc);
        join
    endtask

    task automatic test_back_to_back();
        int st1, st2, rc1, rc2;
        fork
            begin
                push(0, "BEGIN", st1);
                push(0, "end", st2);
            end
            begin
                watch(0, "BEGIN", 1'b0, rc1);
                watch(0, "end", 1'b0, rc2);
            end
        join
        tests_run++;
        if (rc2 - rc1 != 9) begin
            tests_failed++;
            $display("FAIL b2b_clear_gap: got %0d cycles required 9", rc2 - rc1);
        end
    endtask

    task automatic test_drop();
        int st, guard;
        push(1, "abcdefghijkl", st);
        tests_run++;
        if (st != 1) begin
            tests_failed++;
            $display("FAIL drop_in_ready: got %0d stall cycles required 1", st);
        end
        guard = 0;
        while (!done8 && guard < 4) begin
            @(negedge clk);
            guard++;
        end
        tests_run++;
        if (done8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_done_timeout: done=0 required 1");
        end else begin
            tests_run++;
            if ({pass8, ovf8, cnt8} !== {1'b0, 1'b1, 16'd12}) begin
                tests_failed++;
                $display("FAIL drop_verdict: pass=%b ovf=%b cnt=%0d required 0 1 12", pass8, ovf8, cnt8);
            end
            @(negedge clk);
            tests_run++;
            if (done8 !== 1'b0) begin
                tests_failed++;
                $display("FAIL drop_done_width: done still high");
            end
        end
    endtask

    task automatic test_reset_mid_feed();
        int st, guard;
        fork
            push(0, "begin end", st);
            begin
                guard = 0;
                while (!chk_rst16 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
            end
        join
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_reset_values("reset_mid_feed");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL in_ready_after_mid_reset: got %b required 1", in_ready16);
        end
        test_string(0, "begin end", 1'b1);
    endtask

    initial begin
        in_valid16 = 1'b0; in_last16 = 1'b0; in_data16 = 8'h00;
        in_valid8  = 1'b0; in_last8  = 1'b0; in_data8  = 8'h00;
        test_reset();
        test_string(0, "begin end", 1'b1);
        test_string(0, "end begin", 1'b0);
        test_string(0, "begin endx", 1'b0);
        test_back_to_back();
        test_string(1, "abc defg", 1'b1);
        test_drop();
        test_string(1, "ok", 1'b1);
        test_reset_mid_feed();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
